axi_rd_arb: RTL
===============

Name: axi_rd_arb

Overview:
- Two-requester read arbiter in front of the single AXI4-lite read master port of the core.
- Requester 0 is the IFU instruction fetch; requester 1 is the LSU load path.
- Each requester sees a private AR/R channel pair. The block grants exactly one requester, forwards its address, routes the response back, and then re-arbitrates.
- One outstanding transaction at a time. Includes a response watchdog.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, max cycles spent in S_R before a forced error response; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- ifu_ar_valid_i  in  1  IFU read request
- ifu_ar_addr_i  in  ADDR_W  IFU address
- ifu_ar_ready_o  out  1  IFU request accepted
- ifu_r_valid_o  out  1  IFU response valid
- ifu_r_data_o  out  DATA_W  IFU response data
- ifu_r_resp_o  out  2  IFU response code
- ifu_r_ready_i  in  1  IFU response ready
- lsu_ar_valid_i  in  1  LSU read request
- lsu_ar_addr_i  in  ADDR_W  LSU address
- lsu_ar_ready_o  out  1  LSU request accepted
- lsu_r_valid_o  out  1  LSU response valid
- lsu_r_data_o  out  DATA_W  LSU response data
- lsu_r_resp_o  out  2  LSU response code
- lsu_r_ready_i  in  1  LSU response ready
- mst_ar_valid_o  out  1  downstream AR valid
- mst_ar_addr_o  out  ADDR_W  downstream AR address
- mst_ar_ready_i  in  1  downstream AR ready
- mst_r_valid_i  in  1  downstream R valid
- mst_r_data_i  in  DATA_W  downstream R data
- mst_r_resp_i  in  2  downstream R response
- mst_r_ready_o  out  1  downstream R ready

Behaviour:
- Interface decision: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - State = S_IDLE, grant = 0, addr_q = 0, timeout counter = 0, last-winner = LSU.
  - All *_valid_o, *_ready_o and mst_ar_addr_o are 0. All r_data_o/r_resp_o are 0.
- Reset mid-operation: any transaction in flight is dropped with no response to the requester. Downstream sees mst_r_ready_o=0 from the next edge.
- S_IDLE:
  - Fixed priority: LSU wins over IFU when both are valid.
  - Winner's ar_ready_o=1 combinationally in the same cycle; the loser's ar_ready_o=0.
  - On the clock edge: latch addr_q and grant, then go to S_AR.
- S_AR:
  - mst_ar_valid_o=1 and mst_ar_addr_o=addr_q, held stable until mst_ar_ready_i.
  - On handshake: go to S_R and clear the counter.
  - Requester ar_ready_o=0 in this state.
- S_R:
  - For the granted requester only: r_valid_o=mst_r_valid_i, r_data_o=mst_r_data_i, r_resp_o=mst_r_resp_i, mst_r_ready_o=granted r_ready_i.
  - Non-granted r_valid_o=0.
  - On mst_r_valid_i && mst_r_ready_o: go to S_IDLE.
  - Counter increments each cycle without a handshake and saturates.
- Timeout (TIMEOUT_CYC≠0): when the counter reaches TIMEOUT_CYC, go to S_TO.
- S_TO:
  - Granted r_valid_o=1, r_resp_o=2'b10 (SLVERR), r_data_o=0, mst_r_ready_o=1 (drains any late beat).
  - On granted r_ready_i: go to S_IDLE.
- Latency:
  - Request accept at cycle N, mst_ar_valid_o at N+1.
  - With an always-ready slave returning data the cycle after AR: response at N+2, next grant possible at N+3.
- Simultaneous events:
  - A new request arriving in S_AR/S_R/S_TO is held off (ar_ready_o=0). It is not dropped; AXI valid-stability is the requester's duty.
  - A handshake in the same cycle the counter hits its limit is a normal completion, not a timeout.
- Addresses are passed through unchanged. No alignment check.

Optional Feature:
- Macro: YSYX_23060251_ARB_RR_EN.
- Defined: round-robin arbitration. On contention, the requester that did not win last is granted; last-winner updates on every grant.
- Undefined: fixed LSU-over-IFU priority, and the last-winner register is not implemented.

Test Plan:
- IFU only, addr 0x8000_0000, slave always ready, rdata 0x0010_0073, resp 0 → ifu_ar_ready_o pulse cycle 0; mst_ar_addr_o=0x8000_0000 at cycle 1; ifu_r_valid_o with data 0x0010_0073 at cycle 2; lsu_r_valid_o stays 0.
- IFU 0x8000_0004 and LSU 0x8000_1000 both valid in the same cycle:
  - Fixed priority → LSU served first, IFU second.
  - With RR_EN and last winner LSU → IFU served first.
- Slave deasserts mst_ar_ready_i for 3 cycles → mst_ar_valid_o held and addr stable for 4 cycles, then one handshake.
- Granted requester holds r_ready_i=0 for 2 cycles while mst_r_valid_i=1 → mst_r_ready_o=0 for those cycles, data forwarded unchanged, completion on the third cycle.
- TIMEOUT_CYC=4, slave never returns R → after 4 cycles in S_R, granted r_valid_o=1 with r_resp_o=2'b10 and data 0; then back to S_IDLE.
- rst_i asserted in S_R → next cycle state S_IDLE with all valid/ready outputs 0; a new IFU request is granted normally after rst_i drops.

Source files
------------

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester (IFU = 0, LSU = 1) read arbiter in front of a single
// AXI4-lite read master port. One outstanding transaction, with a response watchdog.
// Optional macro YSYX_23060251_ARB_RR_EN: round-robin arbitration on contention.
// Without it, LSU has fixed priority over IFU.
module axi_rd_arb #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ifu_ar_valid_i,
    input  logic [ADDR_W-1:0] ifu_ar_addr_i,
    output logic              ifu_ar_ready_o,
    output logic              ifu_r_valid_o,
    output logic [DATA_W-1:0] ifu_r_data_o,
    output logic [1:0]        ifu_r_resp_o,
    input  logic              ifu_r_ready_i,
    input  logic              lsu_ar_valid_i,
    input  logic [ADDR_W-1:0] lsu_ar_addr_i,
    output logic              lsu_ar_ready_o,
    output logic              lsu_r_valid_o,
    output logic [DATA_W-1:0] lsu_r_data_o,
    output logic [1:0]        lsu_r_resp_o,
    input  logic              lsu_r_ready_i,
    output logic              mst_ar_valid_o,
    output logic [ADDR_W-1:0] mst_ar_addr_o,
    input  logic              mst_ar_ready_i,
    input  logic              mst_r_valid_i,
    input  logic [DATA_W-1:0] mst_r_data_i,
    input  logic [1:0]        mst_r_resp_i,
    output logic              mst_r_ready_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_TO   = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // The counter reaches TIMEOUT_CYC on the edge where it leaves CNT_LIM.
    localparam logic [CNT_W-1:0] CNT_LIM = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;   // 0 = IFU, 1 = LSU
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_any;
    logic              pick_lsu;
    logic              gnt_r_ready;
    logic              r_hs;

`ifdef YSYX_23060251_ARB_RR_EN
    logic              last_q, last_d;     // 1 = LSU won the previous grant

    // Round-robin pick: on contention, grant whoever did not win last time.
    always_comb begin
        pick_lsu = lsu_ar_valid_i && (!ifu_ar_valid_i || !last_q);
    end

    // Last-winner register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority pick: LSU beats IFU.
    always_comb begin
        pick_lsu = lsu_ar_valid_i;
    end
`endif

    assign req_any     = ifu_ar_valid_i || lsu_ar_valid_i;
    assign gnt_r_ready = grant_q ? lsu_r_ready_i : ifu_r_ready_i;
    assign r_hs        = (state_q == S_R) && mst_r_valid_i && gnt_r_ready;

    // Next-state logic: grant, address latch, watchdog counter.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef YSYX_23060251_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    grant_d = pick_lsu;
                    addr_d  = pick_lsu ? lsu_ar_addr_i : ifu_ar_addr_i;
                    state_d = S_AR;
`ifdef YSYX_23060251_ARB_RR_EN
                    last_d  = pick_lsu;
`endif
                end
            end
            S_AR: begin
                if (mst_ar_ready_i) begin
                    state_d = S_R;
                    cnt_d   = '0;
                end
            end
            S_R: begin
                // A handshake wins over a simultaneous watchdog expiry.
                if (r_hs) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if ((TIMEOUT_CYC != 0) && (cnt_q >= CNT_LIM)) begin
                        state_d = S_TO;
                    end
                end
            end
            S_TO: begin
                if (gnt_r_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mst_ar_addr_o = addr_q;

    // Output decode: handshakes and response routing to the granted requester.
    always_comb begin
        ifu_ar_ready_o = 1'b0;
        lsu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        ifu_r_data_o   = '0;
        ifu_r_resp_o   = 2'b00;
        lsu_r_valid_o  = 1'b0;
        lsu_r_data_o   = '0;
        lsu_r_resp_o   = 2'b00;
        mst_ar_valid_o = 1'b0;
        mst_r_ready_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Never acknowledge a request while reset is held.
                ifu_ar_ready_o = !rst_i && ifu_ar_valid_i && !pick_lsu;
                lsu_ar_ready_o = !rst_i && pick_lsu;
            end
            S_AR: begin
                mst_ar_valid_o = 1'b1;
            end
            S_R: begin
                mst_r_ready_o = gnt_r_ready;
                if (grant_q) begin
                    lsu_r_valid_o = mst_r_valid_i;
                    lsu_r_data_o  = mst_r_data_i;
                    lsu_r_resp_o  = mst_r_resp_i;
                end else begin
                    ifu_r_valid_o = mst_r_valid_i;
                    ifu_r_data_o  = mst_r_data_i;
                    ifu_r_resp_o  = mst_r_resp_i;
                end
            end
            S_TO: begin
                // Forced SLVERR; keep R ready high so a late beat is drained.
                mst_r_ready_o = 1'b1;
                if (grant_q) begin
                    lsu_r_valid_o = 1'b1;
                    lsu_r_resp_o  = 2'b10;
                end else begin
                    ifu_r_valid_o = 1'b1;
                    ifu_r_resp_o  = 2'b10;
                end
            end
            default: begin
                mst_r_ready_o = 1'b0;
            end
        endcase
    end

endmodule
